// File: rtl/adder_bcd_serial_n_digits_pkg.sv
// Shared constants for the serial BCD adder: FSM encodings and the largest legal digit.
package adder_bcd_serial_n_digits_pkg;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CHECK = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic [3:0] nines_digit(input logic [3:0] d);
        return BCD_MAX - d;
    endfunction
endpackage

// File: rtl/adder_bcd_serial_n_digits_digit_adder.sv
// One-digit decimal adder: t = a+b+cin, wrapped to 0..9 with a decimal carry.
module bcd_digit_adder
    import adder_bcd_serial_n_digits_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [4:0] t;
    logic [4:0] t_wrap;

    always_comb begin
        t      = {1'b0, a} + {1'b0, b} + {4'b0, cin};
        t_wrap = t - 5'd10;
        if (t > {1'b0, BCD_MAX}) begin
            s    = t_wrap[3:0];
            cout = 1'b1;
        end else begin
            s    = t[3:0];
            cout = 1'b0;
        end
    end
endmodule

// File: rtl/adder_bcd_serial_n_digits_hex.sv
// BCD to active-low 7-segment decoder; seg[0]=a .. seg[6]=g, non-decimal codes blank.
module decoder_hex_10 (
    input  logic [3:0] bcd,
    output logic [6:0] seg
);
    always_comb begin
        case (bcd)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    end
endmodule

// File: rtl/adder_bcd_serial_n_digits.sv
// Serial N-digit packed-BCD adder/subtractor, one digit per clock LSB first, with
// operand validation and 7-segment output of the registered result.
module adder_bcd_serial_n_digits
    import adder_bcd_serial_n_digits_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    op,
    input  logic                    cin,
    input  logic [4*DIGITS-1:0]     X,
    input  logic [4*DIGITS-1:0]     Y,
    output logic                    busy,
    output logic                    done,
    output logic [4*DIGITS-1:0]     sum,
    output logic                    cout,
    output logic                    error,
    output logic [7*(DIGITS+1)-1:0] hex
);
    localparam int              W    = 4 * DIGITS;
    localparam int              CW   = $clog2(DIGITS + 1);
    localparam logic [CW-1:0]   LAST = CW'(DIGITS - 1);

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  x_q, x_d, y_q, y_d, ws_q, ws_d, sum_q, sum_d;
    logic          op_q, op_d, carry_q, carry_d, err_q, err_d;
    logic          cout_q, cout_d, error_q, error_d;
    logic [CW-1:0] idx_q, idx_d;

    logic          all_bcd;
    logic [W-1:0]  y_nines;
    logic [3:0]    dig_s;
    logic          dig_c;

    always_comb begin
        all_bcd = 1'b1;
        y_nines = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (x_q[4*k +: 4] > BCD_MAX || y_q[4*k +: 4] > BCD_MAX) all_bcd = 1'b0;
            y_nines[4*k +: 4] = nines_digit(y_q[4*k +: 4]);
        end
    end

    // Single digit adder shared across all digit positions, indexed by idx_q.
    bcd_digit_adder u_dig (
        .a    (x_q[4*idx_q +: 4]),
        .b    (y_q[4*idx_q +: 4]),
        .cin  (carry_q),
        .s    (dig_s),
        .cout (dig_c)
    );

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        ws_d    = ws_q;
        op_d    = op_q;
        carry_d = carry_q;
        err_d   = err_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        error_d = error_q;
        case (state_q)
            S_IDLE: if (start) begin
                x_d     = X;
                y_d     = Y;
                op_d    = op;
                carry_d = op | cin;
                idx_d   = '0;
                ws_d    = '0;
                err_d   = 1'b0;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (!all_bcd) begin
                    err_d   = 1'b1;
                    ws_d    = '0;
                    carry_d = 1'b0;
                    state_d = S_DONE;
                end else begin
                    if (op_q) y_d = y_nines;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                ws_d[4*idx_q +: 4] = dig_s;
                carry_d            = dig_c;
                idx_d              = idx_q + CW'(1);
                if (idx_q == LAST) state_d = S_DONE;
            end
            default: begin
                sum_d   = ws_q;
                cout_d  = carry_q;
                error_d = err_q;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            ws_q    <= '0;
            op_q    <= 1'b0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            ws_q    <= ws_d;
            op_q    <= op_d;
            carry_q <= carry_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            error_q <= error_d;
        end
    end

    assign busy  = (state_q == S_CHECK) || (state_q == S_RUN);
    assign done  = (state_q == S_DONE);
    assign sum   = sum_q;
    assign cout  = cout_q;
    assign error = error_q;

    // Digit DIGITS displays the carry / no-borrow flag.
    for (genvar g = 0; g <= DIGITS; g++) begin : g_hex
        logic [3:0] d;
        if (g < DIGITS) begin : g_sum
            assign d = sum_q[4*g +: 4];
        end else begin : g_cout
            assign d = {3'b000, cout_q};
        end
        decoder_hex_10 u_hex (
            .bcd (d),
            .seg (hex[7*g +: 7])
        );
    end
endmodule
